// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_bank divider channels.
// Mode and state enums plus the divisor validity rule.
package clk_div_pkg;

  typedef enum logic {
    MODE_CLK    = 1'b0,
    MODE_STROBE = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  function automatic logic div_valid(
    input mode_e       mode,
    input int unsigned div
  );
    return (mode == MODE_CLK) ? (div >= 2) : (div >= 1);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow config, run/idle FSM and
// the posedge/negedge output pair used for exact 50% odd division.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             sync_i,
  output logic             out_o,
  output logic             active_o,
  output logic             cfg_err_o
);

  chan_state_e      st, st_d;
  mode_e            smode, smode_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] sdiv, sdiv_d;
  logic             err_d;
  logic             load;
  logic             wrap;
  logic             p, p_d;
  logic             n;
  logic             odd_clk;

  assign wrap = sync_i || (cnt == sdiv - CNT_W'(1));

  always_comb begin
    st_d    = st;
    cnt_d   = cnt;
    sdiv_d  = sdiv;
    smode_d = smode;
    err_d   = cfg_err_o;
    load    = 1'b0;
    unique case (st)
      ST_IDLE: load = en_i;
      ST_RUN: begin
        if (smode == MODE_STROBE && !en_i) begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end else if (wrap) begin
          if (en_i) begin
            load = 1'b1;
          end else begin
            st_d  = ST_IDLE;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
    if (load) begin
      sdiv_d  = div_i;
      smode_d = mode_e'(mode_i);
      cnt_d   = '0;
      if (div_valid(mode_e'(mode_i), 32'(div_i))) begin
        st_d  = ST_RUN;
        err_d = 1'b0;
      end else begin
        st_d  = ST_IDLE;
        err_d = 1'b1;
      end
    end
    // Output follows the next-state count so it moves with cnt.
    p_d = 1'b0;
    if (st_d == ST_RUN) begin
      if (smode_d == MODE_STROBE)
        p_d = (cnt_d == sdiv_d - CNT_W'(1));
      else
        p_d = (cnt_d < (sdiv_d >> 1));
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      cnt       <= '0;
      sdiv      <= CNT_W'(DEF_DIV);
      smode     <= MODE_CLK;
      cfg_err_o <= 1'b0;
      p         <= 1'b0;
    end else begin
      st        <= st_d;
      cnt       <= cnt_d;
      sdiv      <= sdiv_d;
      smode     <= smode_d;
      cfg_err_o <= err_d;
      p         <= p_d;
    end
  end

  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) n <= 1'b0;
    else        n <= p;
  end

  // The half-cycle extension only applies to a running odd CLK period.
  assign odd_clk  = (st == ST_RUN) && (smode == MODE_CLK) && sdiv[0];
  assign out_o    = p | (n & odd_clk);
  assign active_o = (st == ST_RUN);

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers / strobe generators
// sharing one clock and a common phase-alignment sync.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  input  logic                    sync_i,
  output logic [NUM_CH-1:0]       out_o,
  output logic [NUM_CH-1:0]       active_o,
  output logic [NUM_CH-1:0]       cfg_err_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .en_i      (en_i[c]),
      .mode_i    (mode_i[c]),
      .div_i     (div_i[c*CNT_W +: CNT_W]),
      .sync_i    (sync_i),
      .out_o     (out_o[c]),
      .active_o  (active_o[c]),
      .cfg_err_o (cfg_err_o[c])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank: directed table, corner sequences and
// randomized traffic against a time-based reference model.
module tb_clk_div_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                             clk_in = 1'b0;
  logic                             rst_n;
  logic                             sync_i;
  logic [NUM_CH-1:0]                en_i;
  logic [NUM_CH-1:0]                mode_i;
  logic [NUM_CH-1:0][CNT_W-1:0]     div_v;
  logic [NUM_CH-1:0]                out_o;
  logic [NUM_CH-1:0]                active_o;
  logic [NUM_CH-1:0]                cfg_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  clk_div_bank #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (4)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en_i      (en_i),
    .mode_i    (mode_i),
    .div_i     (div_v),
    .sync_i    (sync_i),
    .out_o     (out_o),
    .active_o  (active_o),
    .cfg_err_o (cfg_err_o)
  );

  typedef struct {
    logic mode;
    int   div;
    int   ncyc;
    int   hi;
    logic act;
    logic err;
  } vec_t;

  vec_t tbl[9];

  // reference model: period start cycle and elapsed-cycle arithmetic
  bit m_run[NUM_CH];
  bit m_m[NUM_CH];
  bit m_err[NUM_CH];
  int m_d[NUM_CH];
  int m_t0[NUM_CH];
  int cyc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(output logic [NUM_CH-1:0] a,
                      output logic [NUM_CH-1:0] b);
    @(posedge clk_in);
    #1 a = out_o;
    @(negedge clk_in);
    #1 b = out_o;
  endtask

  task automatic do_reset();
    en_i   = '0;
    mode_i = '0;
    sync_i = 1'b0;
    div_v  = {NUM_CH{8'd4}};
    rst_n  = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic m_load(input int c);
    m_d[c]   = int'(div_v[c]);
    m_m[c]   = mode_i[c];
    m_t0[c]  = cyc;
    m_run[c] = m_m[c] ? (m_d[c] >= 1) : (m_d[c] >= 2);
    m_err[c] = !m_run[c];
  endtask

  task automatic m_edge();
    cyc++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!m_run[c]) begin
        if (en_i[c]) m_load(c);
      end else if (m_m[c] && !en_i[c]) begin
        m_run[c] = 1'b0;
      end else if (sync_i || (cyc - m_t0[c] == m_d[c])) begin
        if (en_i[c]) m_load(c);
        else m_run[c] = 1'b0;
      end
    end
  endtask

  // late=1: value in the second half of the cycle
  function automatic logic m_out(input int c, input bit late);
    int k;
    k = cyc - m_t0[c];
    if (!m_run[c]) return 1'b0;
    if (m_m[c]) return (k == m_d[c] - 1);
    return late ? (2 * k + 1 < m_d[c]) : (2 * k < m_d[c]);
  endfunction

  logic [NUM_CH-1:0] a, b;
  logic [19:0]       w0;
  logic [19:0]       w1;
  logic [7:0]        act_w;
  int                hi;

  initial begin
    tbl[0] = '{1'b0, 3, 30, 30, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 4, 20, 10, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4, 20, 20, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 5, 25, 25, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 2, 10, 10, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1, 10, 20, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 7, 21, 6, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 0, 5, 0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1, 10, 0, 1'b0, 1'b1};

    en_i   = '0;
    mode_i = '0;
    sync_i = 1'b0;
    div_v  = {NUM_CH{8'd4}};
    rst_n  = 1'b0;
    #12;
    chk("rst_out", 32'(out_o), 32'h0);
    chk("rst_act", 32'(active_o), 32'h0);
    chk("rst_err", 32'(cfg_err_o), 32'h0);

    for (int t = 0; t < 9; t++) begin
      do_reset();
      mode_i[0] = tbl[t].mode;
      div_v[0]  = CNT_W'(tbl[t].div);
      en_i[0]   = 1'b1;
      hi = 0;
      for (int i = 0; i < tbl[t].ncyc; i++) begin
        step(a, b);
        hi += int'(a[0]) + int'(b[0]);
      end
      chk($sformatf("tbl%0d_hi", t), 32'(hi), 32'(tbl[t].hi));
      chk($sformatf("tbl%0d_act", t), 32'(active_o[0]), 32'(tbl[t].act));
      chk($sformatf("tbl%0d_err", t), 32'(cfg_err_o[0]), 32'(tbl[t].err));
    end

    // error flag is sticky in idle, clears on the next valid load
    en_i[0]  = 1'b0;
    div_v[0] = 8'd2;
    step(a, b);
    chk("err_sticky", 32'(cfg_err_o[0]), 32'h1);
    en_i[0] = 1'b1;
    w0 = '0;
    for (int i = 0; i < 4; i++) begin
      step(a, b);
      w0 = {w0[17:0], a[0], b[0]};
    end
    chk("err_clr_wave", 32'(w0[7:0]), 32'hCC);
    chk("err_clr", 32'(cfg_err_o[0]), 32'h0);
    chk("err_clr_act", 32'(active_o[0]), 32'h1);

    // divisor change mid-period lands at the next wrap
    do_reset();
    div_v[0] = 8'd4;
    en_i[0]  = 1'b1;
    w0 = '0;
    for (int i = 0; i < 10; i++) begin
      step(a, b);
      w0 = {w0[17:0], a[0], b[0]};
      if (i == 1) div_v[0] = 8'd6;
    end
    chk("div_chg_wave", 32'(w0), 32'hF0FC0);

    // CLK disable finishes the period, then sync is ignored
    do_reset();
    div_v[0] = 8'd5;
    en_i[0]  = 1'b1;
    w0 = '0;
    act_w = '0;
    for (int i = 0; i < 8; i++) begin
      step(a, b);
      w0 = {w0[17:0], a[0], b[0]};
      act_w = {act_w[6:0], active_o[0]};
      if (i == 1) en_i[0] = 1'b0;
    end
    chk("dis_wave", 32'(w0[15:0]), 32'hF800);
    chk("dis_act", 32'(act_w), 32'hF8);
    sync_i = 1'b1;
    step(a, b);
    sync_i = 1'b0;
    step(a, b);
    chk("dis_sync_act", 32'(active_o[0]), 32'h0);
    chk("dis_sync_out", 32'({a[0], b[0]}), 32'h0);

    // sync aligns two out-of-phase channels
    do_reset();
    div_v[0] = 8'd3;
    div_v[1] = 8'd4;
    en_i[0]  = 1'b1;
    step(a, b);
    en_i[1] = 1'b1;
    for (int i = 0; i < 4; i++) step(a, b);
    sync_i = 1'b1;
    w0 = '0;
    w1 = '0;
    for (int i = 0; i < 4; i++) begin
      step(a, b);
      sync_i = 1'b0;
      w0 = {w0[17:0], a[0], b[0]};
      w1 = {w1[17:0], a[1], b[1]};
    end
    chk("sync_ch0", 32'(w0[7:0]), 32'hE3);
    chk("sync_ch1", 32'(w1[7:0]), 32'hF0);

    // asynchronous reset while the negedge helper holds out high
    do_reset();
    div_v[0] = 8'd3;
    en_i[0]  = 1'b1;
    step(a, b);
    chk("arst_pre", 32'(b[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(out_o), 32'h0);
    chk("arst_act", 32'(active_o), 32'h0);
    #1 rst_n = 1'b1;

    // randomized traffic against the reference model
    do_reset();
    cyc = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 1'b0;
      m_err[c] = 1'b0;
      m_m[c]   = 1'b0;
      m_d[c]   = 4;
      m_t0[c]  = 0;
    end
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(15) == 0) en_i[c] = ~en_i[c];
        if ($urandom_range(19) == 0) mode_i[c] = ~mode_i[c];
        if ($urandom_range(9) == 0) div_v[c] = CNT_W'($urandom_range(12));
      end
      sync_i = ($urandom_range(39) == 0);
      m_edge();
      step(a, b);
      for (int c = 0; c < NUM_CH; c++) begin
        chk($sformatf("rnd_out_p%0d", c), 32'(a[c]), 32'(m_out(c, 1'b0)));
        chk($sformatf("rnd_out_n%0d", c), 32'(b[c]), 32'(m_out(c, 1'b1)));
        chk($sformatf("rnd_act%0d", c), 32'(active_o[c]), 32'(m_run[c]));
        chk($sformatf("rnd_err%0d", c), 32'(cfg_err_o[c]), 32'(m_err[c]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
